rib_sram_slave: RTL

Responder end of the RIB bus: a single-port, byte-maskable on-chip SRAM that answers the core's RIB masters (instruction bus and data bus) through the interconnect.
- Accepts one request at a time, commits writes and samples read data at acceptance, then returns a response after a programmable wait.
- Holds the response until the master is ready.
- Back-to-back transfers are overlapped: a new request is granted in the same cycle an old response is taken.

---
 rtl/rib_sram_slave_pkg.sv | 20 ++
 rtl/rib_defines.v | 14 +
 rtl/rib_sram_array.sv | 34 +++
 rtl/rib_sram_slave.sv | 93 +++++++++
 4 files changed

// File: rtl/rib_sram_slave_pkg.sv
// Types and constants shared by the RIB SRAM slave and its storage array.
`include "rib_defines.v"

package rib_sram_slave_pkg;

  localparam int RIB_DW = `RIB_DW;
  localparam int RIB_BE = RIB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = `RIB_ST_IDLE,
    ST_WAIT = `RIB_ST_WAIT,
    ST_RESP = `RIB_ST_RESP
  } rib_state_e;

  // Wait-counter preload; the counter runs LATENCY-1 .. 0 inside WAIT.
  function automatic logic [3:0] lat_load(input int lat);
    return (lat > 0) ? 4'(lat - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/rib_defines.v
// Shared RIB encodings: transfer direction, slave FSM states and data width.
`ifndef RIB_DEFINES_V
`define RIB_DEFINES_V

`define RIB_WRITE   1'b1
`define RIB_READ    1'b0

`define RIB_ST_IDLE 2'b00
`define RIB_ST_WAIT 2'b01
`define RIB_ST_RESP 2'b10

`define RIB_DW      32

`endif

// File: rtl/rib_sram_array.sv
// Single-port 2^AW x 32 RAM with per-byte write enables and registered read data.
module rib_sram_array
  import rib_sram_slave_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [RIB_BE-1:0] i_be,
  input  logic [AW-1:0]     i_addr,
  input  logic [RIB_DW-1:0] i_wdata,
  output logic [RIB_DW-1:0] o_rdata
);

  logic [RIB_DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < RIB_BE; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Writes return zero; the register only moves on an accepted access so the
  // response data stays put while the master stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_en) o_rdata <= i_we ? '0 : r_mem[i_addr];
  end

endmodule

// File: rtl/rib_sram_slave.sv
// RIB responder: one outstanding request, programmable response wait, overlapped handoff.
module rib_sram_slave
  import rib_sram_slave_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_ribs_addr,
  input  logic              i_ribs_wrcs,
  input  logic [3:0]        i_ribs_mask,
  input  logic [RIB_DW-1:0] i_ribs_wdata,
  output logic [RIB_DW-1:0] o_ribs_rdata,
  input  logic              i_ribs_req,
  output logic              o_ribs_gnt,
  output logic              o_ribs_rsp,
  input  logic              i_ribs_rdy
);

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_range
      $error("rib_sram_slave: LATENCY must be within 0..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LOAD = lat_load(LATENCY);

  rib_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_init;
  logic        w_acc;
  logic        w_we;
  logic        w_unused;

  assign w_acc    = i_ribs_req & o_ribs_gnt;
  assign w_we     = (i_ribs_wrcs == `RIB_WRITE);
  assign w_unused = ^{i_ribs_addr[31:AW+2], i_ribs_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_init  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b1;
      if (w_acc)                               r_cnt <= CNT_LOAD;
      else if (r_state == ST_WAIT && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc) w_state_nxt = (LATENCY > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 0) w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (i_ribs_rdy) begin
          if (i_ribs_req) w_state_nxt = (LATENCY > 0) ? ST_WAIT : ST_RESP;
          else            w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Granting on rdy in RESP is what lets a new request overlap the handoff.
  always_comb begin
    o_ribs_gnt = 1'b0;
    o_ribs_rsp = 1'b0;
    case (r_state)
      ST_IDLE: o_ribs_gnt = r_init;
      ST_RESP: begin
        o_ribs_gnt = i_ribs_rdy;
        o_ribs_rsp = 1'b1;
      end
      default: ;
    endcase
  end

  rib_sram_array #(.AW(AW)) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_acc),
    .i_we    (w_we),
    .i_be    (i_ribs_mask),
    .i_addr  (i_ribs_addr[AW+1:2]),
    .i_wdata (i_ribs_wdata),
    .o_rdata (o_ribs_rdata)
  );

endmodule
